// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and the scancode receiver.
// Holds the transmitter state encoding, cycle-count helpers and their default
// values at 28 MHz, status-byte bit positions and the ZX-Uno register address.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_RELEASE,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    function automatic int us_to_cyc(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return (clk_hz / 1_000) * ms;
    endfunction

    localparam int CLK_HZ_DEFAULT        = 28_000_000;
    localparam int INHIBIT_CYC_DEFAULT   = us_to_cyc(CLK_HZ_DEFAULT, 100);
    localparam int FIRST_CLK_CYC_DEFAULT = ms_to_cyc(CLK_HZ_DEFAULT, 15);
    localparam int EDGE_TMO_CYC_DEFAULT  = us_to_cyc(CLK_HZ_DEFAULT, 2000);

    // Timer wide enough for the 15 ms first-clock wait at 28 MHz (420000).
    localparam int TMR_W          = 24;
    localparam int REQ_CYC        = 16;
    // Bit index of the stop bit: 0..7 data, 8 parity, 9 stop.
    localparam int FRAME_STOP_IDX = 9;

    localparam int STAT_BUSY = 7;
    localparam int STAT_ACK  = 6;
    localparam int STAT_NACK = 5;
    localparam int STAT_TMO  = 4;

    localparam logic [7:0] ZXUNO_PS2_TX_ADDR = 8'h0E;

endpackage

// File: rtl/ps2_host_sender_if.sv
// ZX-Uno register-bank port as seen by one register.
//   zxuno_addr  : current register address
//   zxuno_regwr : write strobe on the data port
//   zxuno_regrd : read strobe on the data port
//   din         : CPU output data
//   dout        : register read data
//   oe_n        : low while dout is valid for the CPU
// master = CPU / bus side, slave = register side.
interface ps2_host_sender_if;
    logic [7:0] zxuno_addr;
    logic       zxuno_regwr;
    logic       zxuno_regrd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe_n;

    modport master (
        output zxuno_addr, zxuno_regwr, zxuno_regrd, din,
        input  dout, oe_n
    );

    modport slave (
        input  zxuno_addr, zxuno_regwr, zxuno_regrd, din,
        output dout, oe_n
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one sampled PS/2 line: 2-FF synchroniser followed by a glitch
// filter whose output level only changes once FILTER_LEN consecutive samples
// agree. One-cycle fall/rise pulses accompany each filtered level change.
//   clk, rst_n : system clock, asynchronous active-low reset
//   line_in    : raw line level
//   level      : filtered level (idle high)
//   fall, rise : one-cycle pulses on filtered 1->0 / 0->1
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall,
    output logic rise
);

    logic                  sync_q1;
    logic                  sync_q2;
    logic [FILTER_LEN-1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            hist_q  <= '1;
            level   <= 1'b1;
            fall    <= 1'b0;
            rise    <= 1'b0;
        end else begin
            // synchroniser
            sync_q1 <= line_in;
            sync_q2 <= sync_q1;
            // glitch filter history
            hist_q  <= {hist_q[FILTER_LEN-2:0], sync_q2};
            // filtered level and edge pulses
            fall    <= 1'b0;
            rise    <= 1'b0;
            if (level && (hist_q == '0)) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end else if (!level && (&hist_q)) begin
                level <= 1'b1;
                rise  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_sender.sv
// PS/2 host-to-device transmitter on the ZX-Uno register bank. A CPU write
// to REG_ADDR sends one command byte to the keyboard (inhibit, request-to-send,
// 8 data bits LSB first, odd parity, stop, device ACK). A CPU read returns
// {busy, ack_ok, nack, timeout, 4'b0}.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   bus                : ZX-Uno register port (slave)
//   ps2clk_in/dat_in   : sampled PS/2 lines
//   ps2clk_drive_low   : 1 = pull the clock line low
//   ps2dat_drive_low   : 1 = pull the data line low
//   busy               : frame in flight; the receiver ignores the lines
module ps2_host_sender
    import ps2_pkg::*;
#(
    parameter int         CLK_HZ          = CLK_HZ_DEFAULT,
    parameter int         INHIBIT_US      = 100,
    parameter int         FIRST_CLK_MS    = 15,
    parameter int         EDGE_TIMEOUT_US = 2000,
    parameter logic [7:0] REG_ADDR        = ZXUNO_PS2_TX_ADDR,
    parameter int         FILTER_LEN      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ps2_host_sender_if.slave bus,
    input  logic             ps2clk_in,
    input  logic             ps2dat_in,
    output logic             ps2clk_drive_low,
    output logic             ps2dat_drive_low,
    output logic             busy
);

    localparam logic [TMR_W-1:0] INHIBIT_LD = TMR_W'(us_to_cyc(CLK_HZ, INHIBIT_US) - 1);
    localparam logic [TMR_W-1:0] REQ_LD     = TMR_W'(REQ_CYC - 1);
    localparam logic [TMR_W-1:0] FIRST_LD   = TMR_W'(ms_to_cyc(CLK_HZ, FIRST_CLK_MS) - 1);
    localparam logic [TMR_W-1:0] EDGE_LD    = TMR_W'(us_to_cyc(CLK_HZ, EDGE_TIMEOUT_US) - 1);

    ps2_state_t       state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [8:0]       frame_q, frame_d;
    logic             clk_low_q, clk_low_d;
    logic             dat_low_q, dat_low_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             nack_q, nack_d;
    logic             tmo_q, tmo_d;
    logic             wr_prev_q;

    logic clk_filt, clk_fall, clk_rise;
    logic dat_filt, dat_fall, dat_rise;
    logic filt_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2clk_in),
        .level   (clk_filt),
        .fall    (clk_fall),
        .rise    (clk_rise)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2dat_in),
        .level   (dat_filt),
        .fall    (dat_fall),
        .rise    (dat_rise)
    );

    assign filt_unused = clk_rise ^ dat_fall ^ dat_rise;

    logic wr_hit, wr_rise, tmr_zero, timed;
    assign wr_hit   = (bus.zxuno_addr == REG_ADDR) && bus.zxuno_regwr;
    assign wr_rise  = wr_hit && !wr_prev_q;
    assign tmr_zero = (cnt_q == '0);
    assign timed    = state_q inside {ST_RELEASE, ST_SHIFT, ST_ACK, ST_WAIT_IDLE};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        clk_low_d = clk_low_q;
        dat_low_d = dat_low_q;
        busy_d    = busy_q;
        ack_d     = ack_q;
        nack_d    = nack_q;
        tmo_d     = tmo_q;

        unique case (state_q)
            ST_IDLE: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                if (wr_rise) begin
                    frame_d   = {~^bus.din, bus.din};
                    ack_d     = 1'b0;
                    nack_d    = 1'b0;
                    tmo_d     = 1'b0;
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                    cnt_d     = INHIBIT_LD;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (tmr_zero) begin
                    dat_low_d = 1'b1;
                    cnt_d     = REQ_LD;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                end
            end
            ST_REQ: begin
                if (tmr_zero) begin
                    // Clock released, data stays low as the start bit.
                    clk_low_d = 1'b0;
                    cnt_d     = FIRST_LD;
                    idx_d     = 4'd0;
                    state_d   = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    if (idx_q == 4'(FRAME_STOP_IDX)) begin
                        dat_low_d = 1'b0;
                        state_d   = ST_ACK;
                    end else begin
                        dat_low_d = ~frame_q[idx_q];
                    end
                    idx_d = (idx_q == 4'hF) ? idx_q : idx_q + 4'd1;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!dat_filt) ack_d  = 1'b1;
                    else           nack_d = 1'b1;
                    idx_d   = (idx_q == 4'hF) ? idx_q : idx_q + 4'd1;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_filt && dat_filt) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Device-paced phases share one watchdog: every device clock edge
        // reloads it, expiry abandons the frame and frees both lines.
        if (timed) begin
            if (clk_fall) begin
                cnt_d = EDGE_LD;
            end else if (tmr_zero) begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                tmo_d     = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end else begin
                cnt_d = cnt_q - TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= 4'd0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            tmo_q     <= 1'b0;
            wr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            clk_low_q <= clk_low_d;
            dat_low_q <= dat_low_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            tmo_q     <= tmo_d;
            wr_prev_q <= wr_hit;
        end
    end

    // Frame shift data carries no reset; it is reloaded on every accepted write.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    logic [7:0] status;
    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy_q;
        status[STAT_ACK]  = ack_q;
        status[STAT_NACK] = nack_q;
        status[STAT_TMO]  = tmo_q;
    end

    assign bus.dout         = status;
    assign bus.oe_n         = ~((bus.zxuno_addr == REG_ADDR) && bus.zxuno_regrd);
    assign ps2clk_drive_low = clk_low_q;
    assign ps2dat_drive_low = dat_low_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_ps2_host_sender.sv
module tb_ps2_host_sender;

    localparam int         HALF      = 200;
    localparam int         INHIB_EXP = 2800;
    localparam int         FIRST_EXP = 14000;
    localparam logic [7:0] REG       = 8'h0E;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_sender_if bus();

    logic clk_dl, dat_dl, busy;
    logic ps2clk_in, ps2dat_in;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic glitch_low  = 1'b0;

    assign ps2clk_in = ~(clk_dl | dev_clk_low | glitch_low);
    assign ps2dat_in = ~(dat_dl | dev_dat_low);

    ps2_host_sender #(
        .CLK_HZ          (14_000_000),
        .INHIBIT_US      (200),
        .FIRST_CLK_MS    (1),
        .EDGE_TIMEOUT_US (200),
        .REG_ADDR        (8'h0E),
        .FILTER_LEN      (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .ps2clk_in        (ps2clk_in),
        .ps2dat_in        (ps2dat_in),
        .ps2clk_drive_low (clk_dl),
        .ps2dat_drive_low (dat_dl),
        .busy             (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(~^d);
        exp_q.push_back(1'b1);
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] d);
        @(negedge clk);
        bus.zxuno_addr  = addr;
        bus.din         = d;
        bus.zxuno_regwr = 1'b1;
        repeat (3) @(negedge clk);
        bus.zxuno_regwr = 1'b0;
        bus.zxuno_addr  = 8'h00;
    endtask

    task automatic read_status(output logic [7:0] val, output logic oe_act, output logic oe_idle);
        @(negedge clk);
        bus.zxuno_addr  = REG;
        bus.zxuno_regrd = 1'b1;
        #1;
        val    = bus.dout;
        oe_act = bus.oe_n;
        @(negedge clk);
        bus.zxuno_regrd = 1'b0;
        #1;
        oe_idle = bus.oe_n;
    endtask

    task automatic wait_not_busy(input string name);
        int t = 0;
        while (busy !== 1'b0 && t < 20000) begin cyc(1); t++; end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy %b after %0d cycles, required 0", name, busy, t);
        end
    endtask

    // Keyboard model: waits for request-to-send, then clocks the frame and
    // compares each sampled bit against the scoreboard.
    task automatic dev_frame(input int nfalls, input bit do_ack, input bit glitch);
        int t = 0;
        bit e;
        while (!(busy === 1'b1 && ps2clk_in === 1'b1 && ps2dat_in === 1'b0)) begin
            cyc(1);
            t++;
            if (t > 20000) begin
                n_checks++; n_fail++;
                $display("FAIL dev_rts_wait: no request-to-send after %0d cycles", t);
                return;
            end
        end
        cyc(HALF);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && do_ack) begin
                dev_dat_low = 1'b1;
                cyc(20);
            end
            dev_clk_low = 1'b1;
            cyc(HALF);
            if (k <= 10) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: bit %0d sampled with no expected value", k);
                end else begin
                    e = exp_q.pop_front();
                    if (ps2dat_in !== e) begin
                        n_fail++;
                        $display("FAIL frame_bit%0d: line %b, required %b", k, ps2dat_in, e);
                    end
                end
            end
            if (k == nfalls && k < 11) return;
            dev_clk_low = 1'b0;
            if (glitch && k <= 10) begin
                cyc(80);
                glitch_low = 1'b1;
                cyc(3);
                glitch_low = 1'b0;
                cyc(HALF - 83);
            end else begin
                cyc(HALF);
            end
        end
        dev_dat_low = 1'b0;
        cyc(HALF);
    endtask

    task automatic test_reset;
        logic [7:0] st;
        logic oa, oi;
        cyc(3);
        n_checks++;
        if ({clk_dl, dat_dl, busy, bus.oe_n} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_outputs: {clk,dat,busy,oe_n}=%b, required 0001", {clk_dl, dat_dl, busy, bus.oe_n});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        read_status(st, oa, oi);
        n_checks++;
        if (st !== 8'h00 || oa !== 1'b0 || oi !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: dout %h oe %b/%b, required 00 0/1", st, oa, oi);
        end
        cpu_write(8'h0F, 8'hED);
        cyc(10);
        n_checks++;
        if (busy !== 1'b0 || clk_dl !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_addr: busy %b clk_low %b, required 0 0", busy, clk_dl);
        end
    endtask

    task automatic test_ack_frame;
        logic [7:0] st;
        logic oa, oi;
        push_frame(8'hED);
        fork
            cpu_write(REG, 8'hED);
            begin
                int t = 0;
                while (clk_dl !== 1'b1 && t < 100) begin cyc(1); t++; end
                t = 0;
                while (dat_dl !== 1'b1 && t < 5000) begin cyc(1); t++; end
                n_checks++;
                if (t < INHIB_EXP || t > INHIB_EXP + 1 || clk_dl !== 1'b1) begin
                    n_fail++;
                    $display("FAIL inhibit_len: %0d cycles clk_low %b, required %0d with clock low", t, clk_dl, INHIB_EXP);
                end
                t = 0;
                while (clk_dl !== 1'b0 && t < 100) begin cyc(1); t++; end
                n_checks++;
                if (t != 16 || dat_dl !== 1'b1) begin
                    n_fail++;
                    $display("FAIL req_len: %0d cycles dat_low %b, required 16 with data low", t, dat_dl);
                end
            end
            dev_frame(11, 1'b1, 1'b0);
        join
        wait_not_busy("ack_busy_end");
        read_status(st, oa, oi);
        n_checks++;
        if (st !== 8'h40 || clk_dl !== 1'b0 || dat_dl !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_status: dout %h lines %b%b, required 40 00", st, clk_dl, dat_dl);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] st;
        logic oa, oi;
        int t = 0;
        @(negedge clk);
        bus.zxuno_addr  = REG;
        bus.din         = 8'hFF;
        bus.zxuno_regwr = 1'b1;
        while (clk_dl !== 1'b1 && t < 100) begin cyc(1); t++; end
        t = 0;
        while (clk_dl !== 1'b0 && t < 5000) begin cyc(1); t++; end
        t = 0;
        while (busy !== 1'b0 && t < 30000) begin cyc(1); t++; end
        n_checks++;
        if (t < FIRST_EXP - 1 || t > FIRST_EXP + 1) begin
            n_fail++;
            $display("FAIL first_clk_tmo: busy cleared %0d cycles after release, required %0d", t, FIRST_EXP);
        end
        cyc(10);
        n_checks++;
        if (busy !== 1'b0 || clk_dl !== 1'b0 || dat_dl !== 1'b0) begin
            n_fail++;
            $display("FAIL held_strobe: busy %b lines %b%b, required 0 00", busy, clk_dl, dat_dl);
        end
        @(negedge clk);
        bus.zxuno_regwr = 1'b0;
        bus.zxuno_addr  = 8'h00;
        read_status(st, oa, oi);
        n_checks++;
        if (st !== 8'h10) begin
            n_fail++;
            $display("FAIL tmo_status: dout %h, required 10", st);
        end
    endtask

    task automatic test_nack;
        logic [7:0] st;
        logic oa, oi;
        push_frame(8'h00);
        fork
            cpu_write(REG, 8'h00);
            dev_frame(11, 1'b0, 1'b0);
        join
        wait_not_busy("nack_busy_end");
        read_status(st, oa, oi);
        n_checks++;
        if (st !== 8'h20) begin
            n_fail++;
            $display("FAIL nack_status: dout %h, required 20", st);
        end
    endtask

    task automatic test_write_while_busy;
        logic [7:0] st;
        logic oa, oi;
        push_frame(8'hC3);
        fork
            begin
                cpu_write(REG, 8'hC3);
                cyc(INHIB_EXP + 16 + HALF * 5);
                read_status(st, oa, oi);
                n_checks++;
                if (st !== 8'h80) begin
                    n_fail++;
                    $display("FAIL busy_status: dout %h, required 80", st);
                end
                cpu_write(REG, 8'h55);
            end
            dev_frame(11, 1'b1, 1'b0);
        join
        wait_not_busy("busywr_busy_end");
        read_status(st, oa, oi);
        n_checks++;
        if (st !== 8'h40 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL busywr_status: dout %h left %0d, required 40 0", st, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] st;
        logic oa, oi;
        push_frame(8'hA5);
        fork
            cpu_write(REG, 8'hA5);
            dev_frame(4, 1'b1, 1'b0);
        join
        n_checks++;
        if (dat_dl !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: dat_low %b busy %b, required 1 1", dat_dl, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({clk_dl, dat_dl, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: {clk,dat,busy}=%b, required 000", {clk_dl, dat_dl, busy});
        end
        dev_clk_low = 1'b0;
        exp_q.delete();
        cyc(3);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        read_status(st, oa, oi);
        n_checks++;
        if (st !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_status: dout %h, required 00", st);
        end
    endtask

    task automatic test_glitch;
        logic [7:0] st;
        logic oa, oi;
        push_frame(8'h96);
        fork
            cpu_write(REG, 8'h96);
            dev_frame(11, 1'b1, 1'b1);
        join
        wait_not_busy("glitch_busy_end");
        read_status(st, oa, oi);
        n_checks++;
        if (st !== 8'h40 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_status: dout %h left %0d, required 40 0", st, exp_q.size());
        end
    endtask

    initial begin
        bus.zxuno_addr  = 8'h00;
        bus.zxuno_regwr = 1'b0;
        bus.zxuno_regrd = 1'b0;
        bus.din         = 8'h00;
        test_reset();
        test_ack_frame();
        test_timeout();
        test_nack();
        test_write_while_busy();
        test_reset_mid_frame();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
